// File: rtl/vx_tcu_drl_fpmul_lanes.sv
`default_nettype none
// =============================================================================
// Module      : vx_tcu_drl_fpmul_lanes
// Description : NUM_LANES-wide, 3-stage exact fp16/bf16 -> fp32 multiplier for
//               the tensor-core dot-product reduction lane. Optional build macro
//               VX_TCU_DRL_DENORM_EN adds subnormal-input support (LZC normalise).
// Revision    : 1.0  initial release
// =============================================================================
module vx_tcu_drl_fpmul_lanes #(
  parameter int NUM_LANES = 4,
  parameter int TAG_W     = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_fmt,
  input  logic [NUM_LANES*16-1:0]   in_a,
  input  logic [NUM_LANES*16-1:0]   in_b,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_LANES*32-1:0]   out_y,
  output logic [NUM_LANES*3-1:0]    out_flags,
  output logic [TAG_W-1:0]          out_tag,
  output logic                      busy
);

  typedef struct packed {
    logic        sgn;
    logic        nan;
    logic        snan;
    logic        inf;
    logic        zero;
    logic [10:0] man;
    logic [9:0]  ebits;
  } op_t;

  // Fraction is left-justified into 10 bits so the quiet-NaN bit is always fr[9].
  function automatic op_t decode(input logic [15:0] x, input logic fmt);
    op_t        o;
    logic [7:0] ex;
    logic [9:0] fr;
    logic       ex_max;
    logic       ex_zero;
    logic       hid;
    o = '0;
    if (fmt) begin
      ex     = x[14:7];
      fr     = {x[6:0], 3'b000};
      ex_max = &x[14:7];
    end else begin
      ex     = {3'b000, x[14:10]};
      fr     = x[9:0];
      ex_max = &x[14:10];
    end
    ex_zero = (ex == 8'd0);
    o.sgn   = x[15];
    o.nan   = ex_max & (|fr);
    o.snan  = o.nan & ~fr[9];
    o.inf   = ex_max & ~(|fr);
`ifdef VX_TCU_DRL_DENORM_EN
    o.zero  = ex_zero & ~(|fr);
    hid     = ~ex_zero;
    o.ebits = ex_zero ? 10'd1 : {2'b00, ex};
`else
    o.zero  = ex_zero;
    hid     = 1'b1;
    o.ebits = {2'b00, ex};
`endif
    o.man   = fmt ? {3'b000, hid, x[6:0]} : {hid, x[9:0]};
    return o;
  endfunction

  logic             en;
  logic             s1_v, s2_v, s3_v;
  logic             s1_fmt, s2_fmt;
  logic [TAG_W-1:0] s1_tag, s2_tag, s3_tag;

  assign en        = ~s3_v | out_ready;
  assign in_ready  = en;
  assign out_valid = s3_v;
  assign out_tag   = s3_tag;
  assign busy      = s1_v | s2_v | s3_v;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v   <= 1'b0;
      s2_v   <= 1'b0;
      s3_v   <= 1'b0;
      s1_fmt <= 1'b0;
      s2_fmt <= 1'b0;
      s1_tag <= '0;
      s2_tag <= '0;
      s3_tag <= '0;
    end else if (en) begin
      s1_v <= in_valid;
      s2_v <= s1_v;
      s3_v <= s2_v;
      if (in_valid) begin
        s1_fmt <= in_fmt;
        s1_tag <= in_tag;
      end
      if (s1_v) begin
        s2_fmt <= s1_fmt;
        s2_tag <= s1_tag;
      end
      if (s2_v) s3_tag <= s2_tag;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    op_t               da, db;
    logic              inf_x_zero;
    logic              s1_sgn, s1_nan, s1_inf, s1_zero, s1_nv;
    logic [10:0]       s1_ma, s1_mb;
    logic signed [9:0] s1_e;
    logic              s2_sgn, s2_nan, s2_inf, s2_zero, s2_nv;
    logic [21:0]       s2_prod;
    logic signed [9:0] s2_e;
    logic [21:0]       pj;
    logic [22:0]       frac;
    logic signed [9:0] e_n;
    logic [31:0]       y;
    logic [2:0]        fl;
    logic [31:0]       s3_y;
    logic [2:0]        s3_fl;
`ifdef VX_TCU_DRL_DENORM_EN
    logic [4:0]        lz;
`else
    logic [22:0]       fj;
`endif

    assign da         = decode(in_a[16*i +: 16], in_fmt);
    assign db         = decode(in_b[16*i +: 16], in_fmt);
    assign inf_x_zero = (da.inf & db.zero) | (da.zero & db.inf);

    // Stage 3: normalise the product and resolve specials / range (NaN > inf > zero > normal).
    always_comb begin
      pj = s2_fmt ? {s2_prod[15:0], 6'b000000} : s2_prod;
`ifdef VX_TCU_DRL_DENORM_EN
      lz = 5'd22;
      for (int k = 0; k < 22; k++) begin
        if (pj[k]) lz = 5'(21 - k);
      end
      // Shifting one past the leading one drops the hidden bit.
      frac = {pj << (lz + 5'd1), 1'b0};
      e_n  = s2_e + 10'sd1 - $signed({5'b00000, lz});
`else
      fj   = {pj[20:0], 2'b00};
      frac = pj[21] ? fj : (fj << 1);
      e_n  = pj[21] ? (s2_e + 10'sd1) : s2_e;
`endif
      y  = {s2_sgn, e_n[7:0], frac};
      fl = 3'b000;
      if (s2_nan) begin
        y  = 32'h7FC0_0000;
        fl = {s2_nv, 2'b00};
      end else if (s2_inf) begin
        y  = {s2_sgn, 8'hFF, 23'd0};
      end else if (s2_zero) begin
        y  = {s2_sgn, 31'd0};
      end else if (e_n >= 10'sd255) begin
        y  = {s2_sgn, 8'hFF, 23'd0};
        fl = 3'b010;
      end else if (e_n <= 10'sd0) begin
        y  = {s2_sgn, 31'd0};
        fl = 3'b001;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s1_sgn  <= 1'b0;
        s1_nan  <= 1'b0;
        s1_inf  <= 1'b0;
        s1_zero <= 1'b0;
        s1_nv   <= 1'b0;
        s1_ma   <= '0;
        s1_mb   <= '0;
        s1_e    <= '0;
        s2_sgn  <= 1'b0;
        s2_nan  <= 1'b0;
        s2_inf  <= 1'b0;
        s2_zero <= 1'b0;
        s2_nv   <= 1'b0;
        s2_prod <= '0;
        s2_e    <= '0;
        s3_y    <= '0;
        s3_fl   <= '0;
      end else if (en) begin
        if (in_valid) begin
          s1_sgn  <= da.sgn ^ db.sgn;
          s1_nan  <= da.nan | db.nan | inf_x_zero;
          s1_inf  <= da.inf | db.inf;
          s1_zero <= da.zero | db.zero;
          s1_nv   <= da.snan | db.snan | inf_x_zero;
          s1_ma   <= da.man;
          s1_mb   <= db.man;
          // bias 127 (bf16): -254+127 ; bias 15 (fp16): -30+127
          s1_e    <= in_fmt ? (da.ebits + db.ebits - 10'd127)
                            : (da.ebits + db.ebits + 10'd97);
        end
        if (s1_v) begin
          s2_sgn  <= s1_sgn;
          s2_nan  <= s1_nan;
          s2_inf  <= s1_inf;
          s2_zero <= s1_zero;
          s2_nv   <= s1_nv;
          s2_prod <= {11'd0, s1_ma} * {11'd0, s1_mb};
          s2_e    <= s1_e;
        end
        if (s2_v) begin
          s3_y  <= y;
          s3_fl <= fl;
        end
      end
    end

    assign out_y[32*i +: 32]   = s3_y;
    assign out_flags[3*i +: 3] = s3_fl;
  end

endmodule
`default_nettype wire

// File: tb/tb_vx_tcu_drl_fpmul_lanes.sv
`default_nettype none
// =============================================================================
// Module      : tb_vx_tcu_drl_fpmul_lanes
// Description : Directed-vector self-checking bench for vx_tcu_drl_fpmul_lanes.
// Revision    : 1.0  initial release
// =============================================================================
module tb_vx_tcu_drl_fpmul_lanes;
  localparam int NL = 4;
  localparam int TW = 8;

`ifdef VX_TCU_DRL_DENORM_EN
  localparam logic [31:0] DEN_Y = 32'h3380_0000;
`else
  localparam logic [31:0] DEN_Y = 32'h0000_0000;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_fmt = 1'b0;
  logic [NL*16-1:0] in_a = '0;
  logic [NL*16-1:0] in_b = '0;
  logic [TW-1:0]    in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [NL*32-1:0] out_y;
  logic [NL*3-1:0]  out_flags;
  logic [TW-1:0]    out_tag;
  logic             busy;

  int n_cmp = 0;
  int n_bad = 0;

  vx_tcu_drl_fpmul_lanes #(.NUM_LANES(NL), .TAG_W(TW)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_flags(out_flags), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_lanes(input string nm, input logic [127:0] y, input logic [11:0] fl,
                             input logic [127:0] ey, input logic [11:0] ef);
    for (int i = 0; i < NL; i++) begin
      check_val($sformatf("%s_y%0d", nm, i), y[32*i +: 32], ey[32*i +: 32]);
      check_val($sformatf("%s_f%0d", nm, i), fl[3*i +: 3], ef[3*i +: 3]);
    end
  endtask

  // Present one transaction on an idle pipe and wait for its result.
  task automatic run_one(input logic fmt, input logic [63:0] a, input logic [63:0] b,
                         input logic [7:0] tg, output logic [127:0] y,
                         output logic [11:0] fl, output logic [7:0] otag);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_fmt = fmt; in_a = a; in_b = b; in_tag = tg; out_ready = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      in_valid = 1'b0;
    end while (!out_valid && lat < 10);
    check_val("latency", lat, 3);
    y = out_y; fl = out_flags; otag = out_tag;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] y;
    logic [11:0]  fl;
    logic [7:0]   tg;
    logic [127:0] held_y;
    logic [7:0]   held_tag;
    logic         held_v;
    int sent, got, cyc, extra;
    logic saw_block;

    #2;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_y", out_y, 0);
    check_val("rst_out_flags", out_flags, 0);
    check_val("rst_out_tag", out_tag, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // fp16: 1*2, inf*0, -inf*1, min-subnormal*1
    run_one(1'b0, {16'h0001, 16'hFC00, 16'h7C00, 16'h3C00},
                  {16'h3C00, 16'h3C00, 16'h0000, 16'h4000}, 8'hA1, y, fl, tg);
    check_lanes("fp16a", y, fl, {DEN_Y, 32'hFF80_0000, 32'h7FC0_0000, 32'h4000_0000},
                {3'b000, 3'b000, 3'b100, 3'b000});
    check_val("fp16a_tag", tg, 8'hA1);

    // fp16: 1.5*1.5 (product MSB set), sNaN*1, -0*1, qNaN*0
    run_one(1'b0, {16'h7E00, 16'h8000, 16'h7C01, 16'h3E00},
                  {16'h0000, 16'h3C00, 16'h3C00, 16'h3E00}, 8'hB2, y, fl, tg);
    check_lanes("fp16b", y, fl, {32'h7FC0_0000, 32'h8000_0000, 32'h7FC0_0000, 32'h4010_0000},
                {3'b000, 3'b000, 3'b100, 3'b000});
    check_val("fp16b_tag", tg, 8'hB2);

    // bf16: overflow, underflow, 1*-2, 1.5*1.5
    run_one(1'b1, {16'h3FC0, 16'h3F80, 16'h0080, 16'h7F00},
                  {16'h3FC0, 16'hC000, 16'h0080, 16'h7F00}, 8'hC3, y, fl, tg);
    check_lanes("bf16", y, fl, {32'h4010_0000, 32'hC000_0000, 32'h0000_0000, 32'h7F80_0000},
                {3'b000, 3'b000, 3'b001, 3'b010});
    check_val("bf16_tag", tg, 8'hC3);

    // Back-to-back stream of 8 with a 5-cycle consumer stall; lane0 = 1.0 * 2^t
    sent = 0; got = 0; cyc = 0; saw_block = 1'b0; held_v = 1'b0;
    held_y = '0; held_tag = '0;
    while (got < 8 && cyc < 80) begin
      @(negedge clk);
      out_ready = !(cyc >= 5 && cyc < 10);
      in_valid  = (sent < 8);
      in_fmt    = 1'b0;
      in_a      = {48'h0, 16'h3C00};
      in_b      = {48'h0, 16'h3C00 + 16'(sent * 1024)};
      in_tag    = 8'(sent);
      #1;
      if (out_valid && !out_ready) begin
        if (!in_ready) saw_block = 1'b1;
        if (held_v) begin
          check_val("hold_y", out_y, held_y);
          check_val("hold_tag", out_tag, held_tag);
        end
        held_v = 1'b1; held_y = out_y; held_tag = out_tag;
      end else begin
        held_v = 1'b0;
      end
      if (out_valid && out_ready) begin
        check_val("strm_tag", out_tag, got);
        check_val("strm_y", out_y, {96'h0, 32'h3F80_0000 + 32'(got) * 32'h0080_0000});
        got++;
      end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check_val("strm_got", got, 8);
    check_val("strm_sent", sent, 8);
    check_val("strm_in_ready_low", saw_block, 1);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check_val("strm_no_dup", extra, 0);

    // Reset with two transactions in flight
    @(negedge clk);
    in_valid = 1'b1; in_fmt = 1'b0; in_a = {48'h0, 16'h3C00}; in_b = {48'h0, 16'h3C00}; in_tag = 8'h55;
    @(negedge clk);
    in_tag = 8'h66;
    @(negedge clk);
    in_valid = 1'b0;
    check_val("pre_rst_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_out_valid", out_valid, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_out_tag", out_tag, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_one(1'b0, {48'h0, 16'h4000}, {48'h0, 16'h4000}, 8'h77, y, fl, tg);
    check_val("post_rst_y0", y[31:0], 32'h4080_0000);
    check_val("post_rst_tag", tg, 8'h77);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check_val("post_rst_no_stale", extra, 0);
    check_val("post_rst_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
